// File: rtl/lmi_iram_arb.sv
// lmi_iram_arb: instruction-RAM ownership arbiter (fetch / external port / invalidate sweep).
// Optional macro LMI_IRAM_ARB_STARVE_EN bounds how long busy fetch can hold off the external port.
module lmi_iram_arb #(
    parameter int VAL_IDX_W     = 7,
    parameter int MAX_FETCH_RUN = 16,
    parameter int RUN_CNT_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RESET_D1_R,
    input  logic                 INVALIDATE,
    input  logic                 FETCH_REQ,
    input  logic                 EXT_REQ_R,
    output logic                 EXT_GNT_R,
    output logic                 FETCH_HALT,
    output logic                 DATA_SEL_EXT,
    output logic [VAL_IDX_W-1:0] VAL_INDEX,
    output logic                 VAL_WE,
    output logic                 VAL_CS,
    output logic                 INV_BUSY
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HAND,
        S_EXT,
        S_INV
    } state_t;

    localparam logic [VAL_IDX_W-1:0] LAST_IDX = '1;

    state_t               r_state;
    state_t               w_nxt;
    logic [VAL_IDX_W-1:0] r_idx;
    logic [VAL_IDX_W-1:0] w_idx_nxt;
    logic                 r_pend;
    logic                 w_pend_nxt;
    logic                 w_ext_go;
    logic                 r_gnt;
    logic                 r_halt;
    logic                 r_inv;
    logic                 r_busy;

`ifdef LMI_IRAM_ARB_STARVE_EN
    localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(MAX_FETCH_RUN);

    logic [RUN_CNT_W-1:0] r_run;

    assign w_ext_go = EXT_REQ_R & (~FETCH_REQ | (r_run == RUN_MAX));

    // Count busy fetch cycles that hold off a pending external request
    always_ff @(posedge CLK or posedge RESET_D1_R) begin
        if (RESET_D1_R) begin
            r_run <= '0;
        end else if (r_state != S_FETCH || w_nxt != S_FETCH || !EXT_REQ_R) begin
            r_run <= '0;
        end else if (FETCH_REQ && r_run != RUN_MAX) begin
            r_run <= r_run + 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{RUN_CNT_W'(MAX_FETCH_RUN)};
    assign w_ext_go     = EXT_REQ_R & ~FETCH_REQ;
`endif

    // Next owner, sweep index and deferred-invalidate flag
    always_comb begin
        w_nxt      = r_state;
        w_idx_nxt  = '0;
        w_pend_nxt = r_pend;
        unique case (r_state)
            S_FETCH: begin
                if (INVALIDATE || r_pend) begin
                    w_nxt      = S_INV;
                    w_pend_nxt = 1'b0;
                end else if (w_ext_go) begin
                    w_nxt = S_HAND;
                end
            end
            S_HAND: begin
                if (INVALIDATE) begin
                    w_nxt      = S_INV;
                    w_pend_nxt = 1'b0;
                end else begin
                    w_nxt = S_EXT;
                end
            end
            S_EXT: begin
                if (!EXT_REQ_R) begin
                    if (r_pend || INVALIDATE) begin
                        w_nxt      = S_INV;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_nxt = S_FETCH;
                    end
                end else if (INVALIDATE) begin
                    w_pend_nxt = 1'b1;
                end
            end
            S_INV: begin
                if (INVALIDATE) begin
                    w_idx_nxt = '0;
                end else if (r_idx == LAST_IDX) begin
                    w_nxt = S_FETCH;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_nxt = S_FETCH;
            end
        endcase
    end

    // State plus registered array-steering outputs decoded from the next owner
    always_ff @(posedge CLK or posedge RESET_D1_R) begin
        if (RESET_D1_R) begin
            r_state <= S_FETCH;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_gnt   <= 1'b0;
            r_halt  <= 1'b0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
            r_gnt   <= (w_nxt == S_EXT);
            r_halt  <= (w_nxt != S_FETCH);
            r_inv   <= (w_nxt == S_INV);
            r_busy  <= (w_nxt == S_INV) | w_pend_nxt;
        end
    end

    assign EXT_GNT_R    = r_gnt;
    assign DATA_SEL_EXT = r_gnt;
    assign FETCH_HALT   = r_halt;
    assign VAL_WE       = r_inv;
    assign VAL_CS       = r_inv;
    assign VAL_INDEX    = r_idx;
    assign INV_BUSY     = r_busy;

endmodule

// File: tb/tb_lmi_iram_arb.sv
// tb_lmi_iram_arb: directed vector table plus multi-cycle sequences for lmi_iram_arb.
// Covers handover latency, invalidate sweep/restart/defer, async reset and fetch starvation.
module tb_lmi_iram_arb;

    logic       CLK = 1'b0;
    logic       RESET_D1_R = 1'b1;
    logic       INVALIDATE = 1'b0;
    logic       FETCH_REQ = 1'b0;
    logic       EXT_REQ_R = 1'b0;
    logic       EXT_GNT_R;
    logic       FETCH_HALT;
    logic       DATA_SEL_EXT;
    logic [6:0] VAL_INDEX;
    logic       VAL_WE;
    logic       VAL_CS;
    logic       INV_BUSY;

    int n_chk = 0;
    int n_err = 0;
    int n_overlap = 0;

    lmi_iram_arb dut (
        .CLK         (CLK),
        .RESET_D1_R  (RESET_D1_R),
        .INVALIDATE  (INVALIDATE),
        .FETCH_REQ   (FETCH_REQ),
        .EXT_REQ_R   (EXT_REQ_R),
        .EXT_GNT_R   (EXT_GNT_R),
        .FETCH_HALT  (FETCH_HALT),
        .DATA_SEL_EXT(DATA_SEL_EXT),
        .VAL_INDEX   (VAL_INDEX),
        .VAL_WE      (VAL_WE),
        .VAL_CS      (VAL_CS),
        .INV_BUSY    (INV_BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (EXT_GNT_R && VAL_WE) n_overlap++;
    end

    typedef struct {
        logic       inv;
        logic       f;
        logic       e;
        logic [5:0] flags;
        int         idx;
    } vec_t;

    function automatic logic [5:0] flags_now();
        return {EXT_GNT_R, FETCH_HALT, DATA_SEL_EXT, VAL_WE, VAL_CS, INV_BUSY};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_D1_R = 1'b1;
        INVALIDATE = 1'b0;
        FETCH_REQ  = 1'b0;
        EXT_REQ_R  = 1'b0;
        tick();
        tick();
        RESET_D1_R = 1'b0;
    endtask

    initial begin
        vec_t vt[11];
        int   cnt;
        int   bad;
        int   guard;

        // {inv, fetch, ext, {gnt,halt,sel,we,cs,busy}, index}
        vt[0]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 6'b000000, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 6'b010000, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 6'b111000, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 6'b111000, 0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 6'b111001, 0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 6'b111001, 0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 6'b010111, 0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 6'b010111, 1};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 6'b010111, 0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 6'b010111, 1};

        #1;
        chk("reset_flags", int'(flags_now()), 0);
        chk("reset_index", int'(VAL_INDEX), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            INVALIDATE = vt[i].inv;
            FETCH_REQ  = vt[i].f;
            EXT_REQ_R  = vt[i].e;
            tick();
            chk($sformatf("vec%0d_flags", i), int'(flags_now()), int'(vt[i].flags));
            chk($sformatf("vec%0d_index", i), int'(VAL_INDEX), vt[i].idx);
        end
        INVALIDATE = 1'b0;

        // Handover latency: HAND after 1 edge, grant from the 2nd, gone 1 edge after drop
        do_reset();
        EXT_REQ_R = 1'b1;
        tick();
        chk("hand_halt", int'({EXT_GNT_R, FETCH_HALT}), 1);
        tick();
        chk("ext_gnt", int'({EXT_GNT_R, DATA_SEL_EXT, FETCH_HALT}), 7);
        for (int i = 0; i < 4; i++) tick();
        chk("ext_held", int'(EXT_GNT_R), 1);
        EXT_REQ_R = 1'b0;
        tick();
        chk("ext_release", int'({EXT_GNT_R, FETCH_HALT, DATA_SEL_EXT}), 0);

        // Full 128-word sweep
        do_reset();
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (int'(VAL_INDEX) != i || !VAL_WE || !VAL_CS || !INV_BUSY || !FETCH_HALT) bad++;
            tick();
        end
        chk("sweep_steps_bad", bad, 0);
        chk("sweep_done", int'({INV_BUSY, VAL_WE, FETCH_HALT, VAL_CS}), 0);
        chk("sweep_done_idx", int'(VAL_INDEX), 0);

        // Restart: second pulse while index 49 shown -> 50 + 128 writes
        do_reset();
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        cnt = int'(VAL_WE);
        guard = 0;
        while (VAL_INDEX != 7'd49 && guard < 300) begin
            tick();
            cnt += int'(VAL_WE);
            guard++;
        end
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        cnt += int'(VAL_WE);
        chk("restart_idx", int'(VAL_INDEX), 0);
        guard = 0;
        while (VAL_WE && guard < 400) begin
            tick();
            cnt += int'(VAL_WE);
            guard++;
        end
        chk("restart_total", cnt, 178);

        // Deferred invalidate during grant
        do_reset();
        EXT_REQ_R = 1'b1;
        tick();
        tick();
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        chk("defer_busy", int'({EXT_GNT_R, INV_BUSY, VAL_WE}), 6);
        for (int i = 0; i < 5; i++) tick();
        chk("defer_hold", int'({EXT_GNT_R, INV_BUSY, VAL_WE}), 6);
        EXT_REQ_R = 1'b0;
        tick();
        cnt = 0;
        guard = 0;
        while (VAL_WE && guard < 300) begin
            cnt++;
            tick();
            guard++;
        end
        chk("defer_sweep_len", cnt, 128);
        chk("defer_after", int'({INV_BUSY, FETCH_HALT}), 0);

        // Invalidate and grant condition together: sweep first, then grant
        do_reset();
        INVALIDATE = 1'b1;
        EXT_REQ_R  = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        chk("inv_wins", int'({EXT_GNT_R, VAL_WE}), 1);
        for (int i = 0; i < 130; i++) tick();
        chk("ext_after_sweep", int'(EXT_GNT_R), 1);
        EXT_REQ_R = 1'b0;

        // Reset mid-sweep is asynchronous and drops the sweep
        do_reset();
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("pre_reset_idx", int'(VAL_INDEX), 30);
        #2;
        RESET_D1_R = 1'b1;
        #1;
        chk("async_rst_flags", int'(flags_now()), 0);
        chk("async_rst_idx", int'(VAL_INDEX), 0);
        tick();
        RESET_D1_R = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cnt += int'(VAL_WE);
        end
        chk("no_sweep_after_rst", cnt, 0);

        // Busy fetch against a waiting external request
        do_reset();
        FETCH_REQ = 1'b1;
        EXT_REQ_R = 1'b1;
`ifdef LMI_IRAM_ARB_STARVE_EN
        cnt = 0;
        guard = 0;
        while (!EXT_GNT_R && guard < 100) begin
            tick();
            guard++;
        end
        chk("starve_grant_edge", guard, 18);
`else
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cnt += int'(EXT_GNT_R);
        end
        chk("strict_fetch_no_gnt", cnt, 0);
`endif
        FETCH_REQ = 1'b0;
        EXT_REQ_R = 1'b0;
        tick();

        chk("gnt_we_overlap", n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
